// File: rtl/pp_pkg.sv
// pp_pkg: shared constants and types for the pipelined processor's fetch path
package pp_pkg;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
  typedef enum logic {INIT, RUN} imem_state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
endpackage

// File: rtl/imem_array.sv
// imem_array: word array with one synchronous write port and one read-first synchronous read port
module imem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // write and read on the same edge; the read sees the pre-write contents, and rdata holds when re is low
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/instr_mem_pp.sv
// instr_mem_pp: programmable registered instruction memory for the IF stage
module instr_mem_pp
  import pp_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                DEPTH      = 64,
  parameter int                AW         = $clog2(DEPTH),
  parameter int                ADDR_MODE  = 0,
  parameter logic [DATA_W-1:0] NOP_INSTR  = DATA_W'(NOP_DEFAULT),
  parameter int                INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pc_in,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic              addr_fault,
  output logic              ready,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [DATA_W-1:0] prog_data
);
  imem_state_t       state, state_nxt;
  logic [AW-1:0]     cnt;
  logic [31:0]       idx;
  logic              run, fault, re, we;
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] wdata, rdata;
  assign run = state == RUN;
  assign idx = ADDR_MODE != 0 ? {2'b00, pc_in[31:2]} : pc_in;
  assign fault = idx >= 32'(DEPTH) || (ADDR_MODE != 0 && pc_in[1:0] != 2'b00);
  // the read port only advances on an accepted good fetch, so rdata doubles as the held instruction
  assign re = run && !flush && !stall && fetch_en && !fault;
  // INIT owns the write port for the NOP fill; afterwards it belongs to the program loader
  always_comb begin
    state_nxt = (!run && cnt == AW'(DEPTH - 1)) ? RUN : state;
    we        = run ? prog_we && 32'(prog_addr) < 32'(DEPTH) : 1'b1;
    waddr     = run ? prog_addr : cnt;
    wdata     = run ? prog_data : NOP_INSTR;
  end
  // sequencer state and fill counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT_CLEAR != 0 ? INIT : RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= run ? cnt : cnt + 1'b1;
    end
  end
  // status flags: flush beats stall, stall holds, otherwise the fetch result is latched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready       <= 1'b0;
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
    end else begin
      ready <= state_nxt == RUN;
      if (run && (flush || !stall)) begin
        instr_valid <= !flush && fetch_en && !fault;
        addr_fault  <= !flush && fetch_en && fault;
      end
    end
  end
  assign instr_out = instr_valid ? rdata : NOP_INSTR;
  imem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clk(clk), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(idx[AW-1:0]), .rdata(rdata)
  );
endmodule

// File: tb/tb_instr_mem_pp.sv
// tb_instr_mem_pp: word-index and byte-address instances against a behavioural fetch model
module tb_instr_mem_pp;
  import pp_pkg::*;
  localparam int DEPTH = 64;
  logic        clk = 0, rst_n = 0;
  logic        fetch_en = 0, stall = 0, flush = 0, prog_we = 0;
  logic [5:0]  prog_addr = 0;
  logic [31:0] prog_data = 0;
  logic [31:0] pc [2];
  logic [31:0] out [2];
  logic        vld [2], flt [2], rdy [2];
  int total = 0, bad = 0;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] e_out [2];
  logic        e_v [2], e_f [2], e_rdy;
  int          left;
  always #5 clk = ~clk;
  instr_mem_pp #(.DEPTH(DEPTH), .ADDR_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .pc_in(pc[0]), .fetch_en(fetch_en), .stall(stall), .flush(flush),
    .instr_out(out[0]), .instr_valid(vld[0]), .addr_fault(flt[0]), .ready(rdy[0]),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data));
  instr_mem_pp #(.DEPTH(DEPTH), .ADDR_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .pc_in(pc[1]), .fetch_en(fetch_en), .stall(stall), .flush(flush),
    .instr_out(out[1]), .instr_valid(vld[1]), .addr_fault(flt[1]), .ready(rdy[1]),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data));
  function automatic longint unsigned ix(int k, logic [31:0] p);
    return k == 1 ? longint'(p >> 2) : longint'(p);
  endfunction
  function automatic logic bad_addr(int k, logic [31:0] p);
    return ix(k, p) >= DEPTH || (k == 1 && p[1:0] != 2'b00);
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // reference: DEPTH fill edges after reset, then flush > stall > fetch, writes land after the read
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_rdy <= 0;
      left  <= DEPTH;
      for (int k = 0; k < 2; k++) begin
        e_out[k] <= 0; e_v[k] <= 0; e_f[k] <= 0;
      end
    end else if (left > 0) begin
      m_mem[DEPTH-left] <= 0;
      left  <= left - 1;
      e_rdy <= left == 1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (flush) begin
          e_out[k] <= 0; e_v[k] <= 0; e_f[k] <= 0;
        end else if (!stall) begin
          e_v[k]   <= fetch_en && !bad_addr(k, pc[k]);
          e_f[k]   <= fetch_en && bad_addr(k, pc[k]);
          e_out[k] <= (fetch_en && !bad_addr(k, pc[k])) ? m_mem[ix(k, pc[k])] : 32'h0;
        end
      end
      if (prog_we && prog_addr < DEPTH) m_mem[prog_addr] <= prog_data;
    end
  end
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready%0d", k), {31'b0, rdy[k]}, {31'b0, e_rdy});
      chk($sformatf("valid%0d", k), {31'b0, vld[k]}, {31'b0, e_v[k]});
      chk($sformatf("fault%0d", k), {31'b0, flt[k]}, {31'b0, e_f[k]});
      chk($sformatf("instr%0d", k), out[k], e_out[k]);
    end
  end
  initial begin
    pc[0] = 0; pc[1] = 0;
    repeat (3) step;
    rst_n = 1;
    for (int i = 1; i <= DEPTH; i++) begin
      step;
      chk("init_ready", {31'b0, rdy[0]}, {31'b0, i == DEPTH});
    end
    fetch_en = 1; pc[0] = 5; pc[1] = 20;
    step;
    chk("t1_instr", out[0], 32'h0); chk("t1_valid", {31'b0, vld[1]}, 32'h1);
    fetch_en = 0; prog_we = 1; prog_addr = 0; prog_data = 32'h0022_8020;
    step;
    prog_addr = 7; prog_data = 32'h1109_0006;
    step;
    prog_we = 0; fetch_en = 1; pc[0] = 0; pc[1] = 0;
    step;
    chk("t2_add0", out[0], 32'h0022_8020); chk("t2_add1", out[1], 32'h0022_8020);
    chk("t2_op_r", {26'b0, out[0][31:26]}, {26'b0, OP_RTYPE});
    pc[0] = 7; pc[1] = 28;
    step;
    chk("t2_beq0", out[0], 32'h1109_0006); chk("t2_beq1", out[1], 32'h1109_0006);
    chk("t2_op_beq", {26'b0, out[1][31:26]}, {26'b0, OP_BEQ});
    stall = 1; pc[0] = 0; pc[1] = 0;
    repeat (3) begin
      step;
      chk("t3_hold", out[0], 32'h1109_0006); chk("t3_hold_v", {31'b0, vld[0]}, 32'h1);
    end
    flush = 1;
    step;
    chk("t3_flush", out[0], 32'h0); chk("t3_flush_v", {31'b0, vld[0]}, 32'h0);
    stall = 0; flush = 0; pc[1] = 32'h1C; pc[0] = 63;
    step;
    chk("t4_1c", out[1], 32'h1109_0006); chk("t4_last_v", {31'b0, vld[0]}, 32'h1);
    pc[1] = 32'h1E; pc[0] = 64;
    step;
    chk("t4_mis_f", {31'b0, flt[1]}, 32'h1); chk("t4_mis_o", out[1], 32'h0);
    chk("t4_depth_f", {31'b0, flt[0]}, 32'h1);
    pc[1] = 32'h100;
    step;
    chk("t4_100_f", {31'b0, flt[1]}, 32'h1);
    prog_we = 1; prog_addr = 3; prog_data = 32'hDEAD_BEEF; pc[0] = 3; pc[1] = 12;
    step;
    chk("t5_old", out[0], 32'h0);
    prog_we = 0;
    step;
    chk("t5_new0", out[0], 32'hDEAD_BEEF); chk("t5_new1", out[1], 32'hDEAD_BEEF);
    for (int i = 0; i < 3000; i++) begin
      prog_we   = $urandom_range(3) == 0;
      prog_addr = 6'($urandom_range(63));
      prog_data = $urandom;
      fetch_en  = $urandom_range(3) != 0;
      stall     = $urandom_range(4) == 0;
      flush     = $urandom_range(9) == 0;
      pc[0]     = $urandom_range(70);
      pc[1]     = $urandom_range(32'h110);
      step;
    end
    prog_we = 0; stall = 0; flush = 0; fetch_en = 1; pc[0] = 3; pc[1] = 12;
    step;
    chk("t6_pre_v", {31'b0, vld[0]}, 32'h1);
    #2 rst_n = 0;
    #1;
    chk("t6_async_v", {31'b0, vld[0]}, 32'h0); chk("t6_async_o", out[0], 32'h0);
    chk("t6_async_r", {31'b0, rdy[1]}, 32'h0);
    step;
    #2 rst_n = 1;
    repeat (30) step;
    #2 rst_n = 0;
    #1;
    chk("t6_mid_r", {31'b0, rdy[0]}, 32'h0);
    #2 rst_n = 1;
    for (int i = 1; i <= DEPTH; i++) begin
      step;
      chk("t6_ready", {31'b0, rdy[0]}, {31'b0, i == DEPTH});
    end
    step;
    chk("t6_cleared", out[0], 32'h0); chk("t6_cleared_v", {31'b0, vld[0]}, 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
